mio_bus_responder: RTL and testbench

Memory/IO bus responder for the multi-cycle MIPS CPU. It accepts the CPU's memory requests (MemRead/MemWrite, address, write data), decodes the address to block RAM or on-chip peripherals, and sequences the RAM's fixed read latency. It returns read data with a one-cycle MIO_ready pulse, which the CPU's IF state waits on. It sits between the CPU control/datapath and the RAM and peripheral blocks.

---
 rtl/mio_pkg.sv | 25 ++
 rtl/mio_addr_decode.sv | 38 +++
 rtl/mio_bus_responder.sv | 135 +++++++++++++
 tb/tb_mio_bus_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared constants for the MIPS memory/IO bus responder: peripheral map,
// FSM state encoding and the latched access kind.
package mio_pkg;

  localparam logic [3:0]  PERIPH_REGION = 4'hF;
  localparam logic [31:0] LED_ADDR      = 32'hF000_0000;
  localparam logic [31:0] SW_ADDR       = 32'hF000_0004;
  localparam logic [31:0] CNT_ADDR      = 32'hF000_0008;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RAM_WAIT = 2'd1,
    ST_PERIPH   = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_RAM = 3'd0,
    OP_LED = 3'd1,
    OP_SW  = 3'd2,
    OP_CNT = 3'd3,
    OP_ERR = 3'd4
  } op_e;

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational decode of a CPU request into RAM, peripheral or error target.
// Outputs are only meaningful while a request is present.
module mio_addr_decode
  import mio_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic        rd_i,
  input  logic        wr_i,
  output logic        is_ram_o,
  output logic        is_led_o,
  output logic        is_sw_o,
  output logic        is_cnt_o,
  output logic        err_o
);

  always_comb begin
    is_ram_o = 1'b0;
    is_led_o = 1'b0;
    is_sw_o  = 1'b0;
    is_cnt_o = 1'b0;
    err_o    = 1'b0;
    // Misalignment and read+write conflicts override any target selection.
    if ((rd_i && wr_i) || (addr_i[1:0] != 2'b00)) begin
      err_o = 1'b1;
    end else if (addr_i[31:28] != PERIPH_REGION) begin
      is_ram_o = 1'b1;
    end else if (addr_i == LED_ADDR) begin
      is_led_o = 1'b1;
    end else if ((addr_i == SW_ADDR) && !wr_i) begin
      is_sw_o = 1'b1;
    end else if ((addr_i == CNT_ADDR) && !wr_i) begin
      is_cnt_o = 1'b1;
    end else begin
      err_o = 1'b1;
    end
  end

endmodule

// File: rtl/mio_bus_responder.sv
// Memory/IO bus responder: sequences RAM latency, serves LED/switch/counter
// registers and returns a one-cycle MIO_ready pulse to the multi-cycle CPU.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for MemRead/MemWrite; latches address and data
// RAM_WAIT | RAM_LAT cycles for RAM read data (down-counter)
// PERIPH   | single-cycle register access or error response
// DONE     | MIO_ready high, Data_in valid; back to IDLE
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int          RAM_AW   = 10,
  parameter int          RAM_LAT  = 1,
  parameter logic [31:0] CNT_INIT = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       Data_out,
  output logic              MIO_ready,
  output logic [31:0]       Data_in,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic              bus_err
);

  logic is_ram, is_led, is_sw, is_cnt, dec_err;

  mio_addr_decode u_decode (
    .addr_i   (Addr_out),
    .rd_i     (MemRead),
    .wr_i     (MemWrite),
    .is_ram_o (is_ram),
    .is_led_o (is_led),
    .is_sw_o  (is_sw),
    .is_cnt_o (is_cnt),
    .err_o    (dec_err)
  );

  state_e            state_q;
  op_e               op_q;
  logic [2:0]        wait_q;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       cnt_q;
  logic              mio_ready_q;
  logic [31:0]       data_in_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [15:0]       led_q;
  logic              bus_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ERR;
      wait_q      <= 3'd0;
      wr_q        <= 1'b0;
      wdata_q     <= 32'h0;
      cnt_q       <= CNT_INIT;
      mio_ready_q <= 1'b0;
      data_in_q   <= 32'h0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      led_q       <= 16'h0;
      bus_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_q + 32'd1;
      ram_we_q    <= 1'b0;
      mio_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (MemRead || MemWrite) begin
            wr_q    <= MemWrite;
            wdata_q <= Data_out;
            if (dec_err) bus_err_q <= 1'b1;
            if (is_ram) begin
              op_q       <= OP_RAM;
              ram_addr_q <= Addr_out[RAM_AW+1:2];
              ram_we_q   <= MemWrite;
              wait_q     <= 3'(RAM_LAT - 1);
              state_q    <= ST_RAM_WAIT;
            end else begin
              if (is_led)      op_q <= OP_LED;
              else if (is_sw)  op_q <= OP_SW;
              else if (is_cnt) op_q <= OP_CNT;
              else             op_q <= OP_ERR;
              state_q <= ST_PERIPH;
            end
          end
        end
        ST_RAM_WAIT: begin
          if (wait_q == 3'd0) begin
            if (!wr_q) data_in_q <= ram_dout;
            mio_ready_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        ST_PERIPH: begin
          case (op_q)
            OP_LED: begin
              if (wr_q) led_q <= wdata_q[15:0];
              else      data_in_q <= {16'h0, led_q};
            end
            OP_SW:   data_in_q <= {16'h0, sw_in};
            OP_CNT:  data_in_q <= cnt_q;
            default: data_in_q <= 32'h0;
          endcase
          mio_ready_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MIO_ready = mio_ready_q;
  assign Data_in   = data_in_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_din   = wdata_q;
  assign led_out   = led_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder: one instance with RAM_LAT=1 and one
// with RAM_LAT=3 (counter preloaded near wrap), each behind a small RAM model.
module tb_mio_bus_responder;

  typedef struct packed {
    logic [31:0] data;
    logic        chk_d;
    logic [7:0]  lat;
    logic [31:0] accept;
  } sb_t;

  localparam logic [31:0] CNT3_INIT = 32'hFFFF_FFF0;

  logic clk, reset;
  logic mr1, mw1, mr3, mw3;
  logic [31:0] a1, wd1, a3, wd3;
  logic [15:0] sw;

  logic        mio_ready1, ram_we1, err1, mio_ready3, ram_we3, err3;
  logic [31:0] data_in1, ram_din1, ram_dout1, data_in3, ram_din3, ram_dout3;
  logic [9:0]  ram_addr1, ram_addr3, p1_3, p2_3;
  logic [15:0] led1, led3;

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];

  int cyc, n_cmp, n_bad, rdy1, rdy3, we1, we3;
  logic [31:0] cnt1_m, cnt3_m, last1, last3, we_addr1, we_data1;
  sb_t   sb1[$], sb3[$];
  string tq1[$], tq3[$];

  mio_bus_responder #(.RAM_AW(10), .RAM_LAT(1)) dut (
    .clk(clk), .reset(reset), .MemRead(mr1), .MemWrite(mw1), .Addr_out(a1),
    .Data_out(wd1), .MIO_ready(mio_ready1), .Data_in(data_in1), .ram_addr(ram_addr1),
    .ram_we(ram_we1), .ram_din(ram_din1), .ram_dout(ram_dout1), .sw_in(sw),
    .led_out(led1), .bus_err(err1));

  mio_bus_responder #(.RAM_AW(10), .RAM_LAT(3), .CNT_INIT(CNT3_INIT)) dut3 (
    .clk(clk), .reset(reset), .MemRead(mr3), .MemWrite(mw3), .Addr_out(a3),
    .Data_out(wd3), .MIO_ready(mio_ready3), .Data_in(data_in3), .ram_addr(ram_addr3),
    .ram_we(ram_we3), .ram_din(ram_din3), .ram_dout(ram_dout3), .sw_in(sw),
    .led_out(led3), .bus_err(err3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM models: latency 1 reads combinationally, latency 3 through two address stages.
  always @(posedge clk) begin
    if (ram_we1) mem1[ram_addr1] <= ram_din1;
    if (ram_we3) mem3[ram_addr3] <= ram_din3;
    p1_3 <= ram_addr3;
    p2_3 <= p1_3;
    cyc  <= cyc + 1;
  end
  assign ram_dout1 = mem1[ram_addr1];
  assign ram_dout3 = mem3[p2_3];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt1_m <= 32'h0;
      cnt3_m <= CNT3_INIT;
    end else begin
      cnt1_m <= cnt1_m + 32'd1;
      cnt3_m <= cnt3_m + 32'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input bit s3);
    sb_t   it;
    string tag;
    logic  [31:0] din;
    din = s3 ? data_in3 : data_in1;
    if ((s3 ? sb3.size() : sb1.size()) == 0) begin
      chk(s3 ? "ready3_unexpected" : "ready1_unexpected", 64'd1, 64'd0);
      return;
    end
    if (s3) begin it = sb3.pop_front(); tag = tq3.pop_front(); last3 = din; end
    else    begin it = sb1.pop_front(); tag = tq1.pop_front(); last1 = din; end
    chk({tag, "_lat"}, 64'(cyc - int'(it.accept) + 1), 64'(it.lat));
    if (it.chk_d) chk({tag, "_data"}, din, it.data);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mio_ready1) begin rdy1++; mon(1'b0); end
      if (mio_ready3) begin rdy3++; mon(1'b1); end
      if (ram_we1) begin we1++; we_addr1 = {22'h0, ram_addr1}; we_data1 = ram_din1; end
      if (ram_we3) we3++;
    end
  end

  task automatic drive(input bit s3, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (s3) begin mr3 = rd; mw3 = wr; a3 = a; wd3 = wd; end
    else    begin mr1 = rd; mw1 = wr; a1 = a; wd1 = wd; end
  endtask

  // Drive one request, push its expectation at acceptance, wait for completion.
  task automatic access(input bit s3, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit chk_d, input bit use_cnt, input logic [31:0] exp_d,
                        input int lat, input string tag);
    sb_t it;
    @(negedge clk);
    drive(s3, rd, wr, a, wd);
    @(posedge clk);
    @(negedge clk);
    it.data   = use_cnt ? (s3 ? cnt3_m : cnt1_m) : exp_d;
    it.chk_d  = chk_d;
    it.lat    = 8'(lat);
    it.accept = 32'(cyc);
    if (s3) begin sb3.push_back(it); tq3.push_back(tag); end
    else    begin sb1.push_back(it); tq1.push_back(tag); end
    for (int i = 0; i < 20; i++) begin
      if ((s3 ? sb3.size() : sb1.size()) == 0) break;
      @(negedge clk);
      #1;
    end
    chk({tag, "_pending"}, 64'(s3 ? sb3.size() : sb1.size()), 64'd0);
    if (s3) begin sb3.delete(); tq3.delete(); end
    else    begin sb1.delete(); tq1.delete(); end
    drive(s3, 1'b0, 1'b0, a, wd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, r0;
    logic [31:0] f;
    n_cmp = 0; n_bad = 0; cyc = 0; rdy1 = 0; rdy3 = 0; we1 = 0; we3 = 0;
    last1 = 0; last3 = 0; we_addr1 = 0; we_data1 = 0; sw = 16'h0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ctl1", {mio_ready1, ram_we1, err1, ram_addr1, led1}, 64'd0);
    chk("rst_data1", {data_in1, ram_din1}, 64'd0);
    chk("rst_ctl3", {mio_ready3, ram_we3, err3, ram_addr3, led3}, 64'd0);
    chk("rst_data3", {data_in3, ram_din3}, 64'd0);

    // RAM write then read back, RAM_LAT = 1
    w0 = we1;
    access(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 2, "ram_wr");
    chk("ram_wr_pulses", 64'(we1 - w0), 64'd1);
    chk("ram_wr_addr", we_addr1, 32'd4);
    chk("ram_wr_din", we_data1, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 2, "ram_rd");

    // Peripherals
    access(1'b0, 1'b0, 1'b1, 32'hF000_0000, 32'h0000_A5A5, 1'b0, 1'b0, 32'h0, 2, "led_wr");
    chk("led_out", led1, 16'hA5A5);
    sw = 16'h1234;
    access(1'b0, 1'b1, 1'b0, 32'hF000_0004, 32'h0, 1'b1, 1'b0, 32'h0000_1234, 2, "sw_rd");
    access(1'b0, 1'b1, 1'b0, 32'hF000_0000, 32'h0, 1'b1, 1'b0, 32'h0000_A5A5, 2, "led_rd");
    access(1'b0, 1'b1, 1'b0, 32'hF000_0008, 32'h0, 1'b1, 1'b1, 32'h0, 2, "cnt_a");
    f = last1;
    access(1'b0, 1'b1, 1'b0, 32'hF000_0008, 32'h0, 1'b1, 1'b1, 32'h0, 2, "cnt_b");
    chk("cnt_delta", last1 - f, 32'd3);
    chk("err_clean", err1, 1'b0);

    // Error cases: no RAM strobe, zero data, sticky bus_err
    w0 = we1;
    access(1'b0, 1'b1, 1'b0, 32'h0000_0002, 32'h0, 1'b1, 1'b0, 32'h0, 2, "misalign");
    chk("misalign_err", err1, 1'b1);
    access(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h1111_2222, 1'b1, 1'b0, 32'h0, 2, "rdwr_both");
    access(1'b0, 1'b1, 1'b0, 32'hF000_000C, 32'h0, 1'b1, 1'b0, 32'h0, 2, "unmapped");
    access(1'b0, 1'b0, 1'b1, 32'hF000_0004, 32'h0000_7777, 1'b0, 1'b0, 32'h0, 2, "sw_wr");
    chk("err_no_we", 64'(we1 - w0), 64'd0);
    chk("led_kept", led1, 16'hA5A5);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 2, "ram_intact");
    chk("err_sticky", err1, 1'b1);

    // RAM_LAT = 3 instance
    access(1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0, 4, "l3_wr");
    access(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 32'h0BAD_F00D, 4, "l3_rd");
    access(1'b1, 1'b1, 1'b0, 32'hF000_0008, 32'h0, 1'b1, 1'b1, 32'h0, 2, "cnt_wrap");
    chk("cnt_wrapped", {31'h0, last3 < 32'h100}, 64'd1);

    // Reset during RAM_WAIT aborts the read
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    @(posedge clk);
    @(negedge clk);
    r0 = rdy3;
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("abort_outs3", {mio_ready3, ram_we3, data_in3}, 64'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_ready", 64'(rdy3 - r0), 64'd0);
    chk("abort_led_clr", led1, 16'h0);
    chk("abort_err_clr", err1, 1'b0);
    access(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 32'h0BAD_F00D, 4, "post_rst_rd");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
